fan_mode_scheduler: RTL

Sequencing controller for the range-hood fan gear. Accepts single-cycle mode requests from the debounced key front end and decides the active gear under the hood's mode rules. It times the hurricane (gear 3) and self-clean runs and accumulates fan run time against a user limit to raise a cleaning reminder. It drives the gear and mode-display logic downstream.

---
 rtl/fan_pkg.sv | 39 +++
 rtl/tick_gen.sv | 28 ++
 rtl/fan_mode_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fan_pkg.sv
// rtl/fan_pkg.sv - shared state encoding, gear constants and default durations for the fan scheduler
package fan_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_GEAR1     = 3'd1,
        ST_GEAR2     = 3'd2,
        ST_HURRICANE = 3'd3,
        ST_CLEAN     = 3'd4
    } fan_state_t;

    typedef enum logic [2:0] {
        REQ_NONE   = 3'd0,
        REQ_FIRST  = 3'd1,
        REQ_SECOND = 3'd2,
        REQ_THIRD  = 3'd3,
        REQ_CLEAN  = 3'd4
    } fan_req_t;

    localparam logic [1:0] GEAR_OFF = 2'd0;
    localparam logic [1:0] GEAR_1   = 2'd1;
    localparam logic [1:0] GEAR_2   = 2'd2;
    localparam logic [1:0] GEAR_3   = 2'd3;

    localparam int DEFAULT_CLK_HZ      = 100_000_000;
    localparam int DEFAULT_HURRICANE_S = 60;
    localparam int DEFAULT_CLEAN_S     = 180;

    // Only the highest-priority pulse is considered; whether it may act is decided per state.
    function automatic fan_req_t top_request(input logic first, input logic second,
                                             input logic third, input logic clean);
        if (first)  return REQ_FIRST;
        if (second) return REQ_SECOND;
        if (third)  return REQ_THIRD;
        if (clean)  return REQ_CLEAN;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-second prescaler with restart, tick high while prescaler = CLK_HZ-1
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int             W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0]   LAST = W'(CLK_HZ - 1);

    logic [W-1:0] r_prescaler;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_prescaler <= '0;
        end else if (r_prescaler == LAST) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

    assign tick = (r_prescaler == LAST);

endmodule

// File: rtl/fan_mode_scheduler.sv
// rtl/fan_mode_scheduler.sv - range-hood gear FSM with timed hurricane/clean runs and run-time reminder
module fan_mode_scheduler
    import fan_pkg::*;
#(
    parameter int CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int HURRICANE_S = DEFAULT_HURRICANE_S,
    parameter int CLEAN_S     = DEFAULT_CLEAN_S
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_on,
    input  logic        req_first,
    input  logic        req_second,
    input  logic        req_third,
    input  logic        req_clean,
    input  logic [31:0] work_time_limit,
    output logic [1:0]  gear,
    output logic        clean_active,
    output logic [7:0]  countdown,
    output logic [31:0] work_time,
    output logic        reminder,
    output logic        hurricane_used
);

    localparam logic [7:0] HUR_LOAD   = 8'(HURRICANE_S);
    localparam logic [7:0] CLEAN_LOAD = 8'(CLEAN_S);

    fan_state_t  r_state, w_state_next;
    logic [7:0]  r_countdown, w_countdown_next;
    logic [31:0] r_work_time, w_work_time_next;
    logic        r_hurricane_used, w_hurricane_used_next;
    logic        r_reminder;
    logic        w_restart;
    logic        w_tick;
    fan_req_t    w_req;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    assign w_req = top_request(req_first, req_second, req_third, req_clean);

    always_comb begin
        w_state_next          = r_state;
        w_countdown_next      = r_countdown;
        w_work_time_next      = r_work_time;
        w_hurricane_used_next = r_hurricane_used;
        w_restart             = 1'b0;

        if (!power_on) begin
            w_state_next          = ST_OFF;
            w_countdown_next      = 8'd0;
            w_hurricane_used_next = 1'b0;
            w_restart             = 1'b1;
        end else begin
            if (w_tick && (r_state inside {ST_GEAR1, ST_GEAR2, ST_HURRICANE})
                       && (r_work_time != 32'hFFFF_FFFF)) begin
                w_work_time_next = r_work_time + 32'd1;
            end

            case (r_state)
                ST_OFF: begin
                    case (w_req)
                        REQ_FIRST:  w_state_next = ST_GEAR1;
                        REQ_SECOND: w_state_next = ST_GEAR2;
                        REQ_THIRD: begin
                            if (!r_hurricane_used) begin
                                w_state_next          = ST_HURRICANE;
                                w_countdown_next      = HUR_LOAD;
                                w_hurricane_used_next = 1'b1;
                                w_restart             = 1'b1;
                            end
                        end
                        REQ_CLEAN: begin
                            w_state_next     = ST_CLEAN;
                            w_countdown_next = CLEAN_LOAD;
                            w_restart        = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_GEAR1: if (w_req == REQ_SECOND) w_state_next = ST_GEAR2;
                ST_GEAR2: if (w_req == REQ_FIRST)  w_state_next = ST_GEAR1;
                ST_HURRICANE: begin
                    if (w_tick) begin
                        if (r_countdown == 8'd1) begin
                            w_state_next     = ST_GEAR2;
                            w_countdown_next = 8'd0;
                        end else begin
                            w_countdown_next = r_countdown - 8'd1;
                        end
                    end
                end
                ST_CLEAN: begin
                    // A completed clean resets the filter run-time account.
                    if (w_tick) begin
                        if (r_countdown == 8'd1) begin
                            w_state_next     = ST_OFF;
                            w_countdown_next = 8'd0;
                            w_work_time_next = 32'd0;
                        end else begin
                            w_countdown_next = r_countdown - 8'd1;
                        end
                    end
                end
                default: w_state_next = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_OFF;
            r_countdown      <= 8'd0;
            r_work_time      <= 32'd0;
            r_hurricane_used <= 1'b0;
            r_reminder       <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_countdown      <= w_countdown_next;
            r_work_time      <= w_work_time_next;
            r_hurricane_used <= w_hurricane_used_next;
            r_reminder       <= (work_time_limit != 32'd0) && (r_work_time >= work_time_limit);
        end
    end

    always_comb begin
        gear = GEAR_OFF;
        case (r_state)
            ST_GEAR1:     gear = GEAR_1;
            ST_GEAR2:     gear = GEAR_2;
            ST_HURRICANE: gear = GEAR_3;
            default:      gear = GEAR_OFF;
        endcase
    end

    assign clean_active   = (r_state == ST_CLEAN);
    assign countdown      = r_countdown;
    assign work_time      = r_work_time;
    assign reminder       = r_reminder;
    assign hurricane_used = r_hurricane_used;

endmodule
